// File: rtl/freelist_pkg.sv
`default_nettype none
// ============================================================================
// Module      : freelist_pkg
// Description : Shared sizing constants for the rename-stage physical register
//               free list. They set the default geometry of freelist and its
//               slot-select helper.
// Contents    : C_SCALAR          - allocate/free ports per cycle
//               C_PREG_NUM        - physical registers
//               C_ARCH_NUM        - architectural registers (RAT entries)
//               C_FL_SIZE         - free-list capacity
//               C_PREG_IDX_WIDTH  - physical tag width
// Revision    : 1.0 - initial release
// ============================================================================
package freelist_pkg;

  localparam int C_SCALAR         = 2;
  localparam int C_PREG_NUM       = 64;
  localparam int C_ARCH_NUM       = 32;
  localparam int C_FL_SIZE        = C_PREG_NUM - C_ARCH_NUM;
  localparam int C_PREG_IDX_WIDTH = $clog2(C_PREG_NUM);

endpackage : freelist_pkg
`default_nettype wire

// File: rtl/freelist_slot_select.sv
`default_nettype none
// ============================================================================
// Module      : freelist_slot_select
// Description : Combinational compaction helper. Counts the set bits of a
//               per-slot valid vector and gives each slot the number of valid
//               slots below it, i.e. its offset from the current pointer.
// Ports       : valid [SCALAR]         in  per-slot valid
//               count                  out popcount(valid)
//               pos   [SCALAR][SEL_W]  out valid slots strictly below slot s
// Revision    : 1.0 - initial release
// ============================================================================
module freelist_slot_select
  import freelist_pkg::*;
#(
  parameter int SCALAR = C_SCALAR
) (
  input  logic [SCALAR-1:0]                          valid,
  output logic [$clog2(SCALAR+1)-1:0]                count,
  output logic [SCALAR-1:0][$clog2(SCALAR+1)-1:0]    pos
);

  localparam int SEL_W = $clog2(SCALAR + 1);

  logic [SEL_W-1:0] w_run;

  always_comb begin
    w_run = '0;
    pos   = '0;
    for (int s = 0; s < SCALAR; s++) begin
      pos[s] = w_run;
      w_run  = w_run + SEL_W'(valid[s]);
    end
    count = w_run;
  end

endmodule : freelist_slot_select
`default_nettype wire

// File: rtl/freelist.sv
`default_nettype none
// ============================================================================
// Module      : freelist
// Description : Physical-register free list for the 2-way rename stage.
//               Circular buffer of FL_SIZE tags with head (allocate), tail
//               (free) and rhead (committed head) pointers, each carrying a
//               wrap bit. Rollback rewinds head to the committed head; the
//               squashed tags are still in the buffer so nothing is copied.
// Ports       : clock, reset     in  clock, synchronous active-high reset
//               stall            in  dispatch stalled, no allocation commits
//               rollback         in  squash all non-retired instructions
//               alloc_req   [S]  in  per-slot allocation request
//               alloc_ok         out all requested slots can be granted
//               alloc_preg  [S]  out granted tag per slot (0 if not requested)
//               retire_en   [S]  in  per-slot retire with a destination
//               retire_told [S]  in  T_old tag returned to the list
//               num_free         out current free count
// Revision    : 1.0 - initial release
// ============================================================================
module freelist
  import freelist_pkg::*;
#(
  parameter int SCALAR         = C_SCALAR,
  parameter int PREG_NUM       = C_PREG_NUM,
  parameter int ARCH_NUM       = C_ARCH_NUM,
  parameter int FL_SIZE        = PREG_NUM - ARCH_NUM,
  parameter int PREG_IDX_WIDTH = $clog2(PREG_NUM)
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   stall,
  input  logic                                   rollback,
  input  logic [SCALAR-1:0]                      alloc_req,
  output logic                                   alloc_ok,
  output logic [SCALAR-1:0][PREG_IDX_WIDTH-1:0]  alloc_preg,
  input  logic [SCALAR-1:0]                      retire_en,
  input  logic [SCALAR-1:0][PREG_IDX_WIDTH-1:0]  retire_told,
  output logic [$clog2(FL_SIZE+1)-1:0]           num_free
);

  localparam int IDX_W = (FL_SIZE > 1) ? $clog2(FL_SIZE) : 1;
  localparam int CNT_W = $clog2(FL_SIZE + 1);
  localparam int SEL_W = $clog2(SCALAR + 1);

  // Buffer index advanced by n, modulo FL_SIZE (n never exceeds SCALAR).
  function automatic logic [IDX_W-1:0] idx_add(input logic [IDX_W-1:0] idx,
                                               input logic [SEL_W-1:0] n);
    logic [IDX_W:0] sum;
    sum = {1'b0, idx} + (IDX_W+1)'(n);
    if (sum >= (IDX_W+1)'(FL_SIZE)) sum = sum - (IDX_W+1)'(FL_SIZE);
    return sum[IDX_W-1:0];
  endfunction

  // Pointer {wrap, idx} advanced by n; the wrap bit toggles on crossing.
  function automatic logic [IDX_W:0] ptr_add(input logic [IDX_W:0] ptr,
                                             input logic [SEL_W-1:0] n);
    logic [IDX_W:0] sum;
    sum = {1'b0, ptr[IDX_W-1:0]} + (IDX_W+1)'(n);
    if (sum >= (IDX_W+1)'(FL_SIZE)) begin
      sum = sum - (IDX_W+1)'(FL_SIZE);
      return {~ptr[IDX_W], sum[IDX_W-1:0]};
    end
    return {ptr[IDX_W], sum[IDX_W-1:0]};
  endfunction

  // Forward distance from one pointer to another (0..FL_SIZE). Differing wrap
  // bits mean the later pointer has crossed the end once more.
  function automatic logic [CNT_W-1:0] ptr_dist(input logic [IDX_W:0] from,
                                                input logic [IDX_W:0] to);
    logic [IDX_W+1:0] d;
    d = {2'b00, to[IDX_W-1:0]} - {2'b00, from[IDX_W-1:0]};
    if (from[IDX_W] != to[IDX_W]) d = d + (IDX_W+2)'(FL_SIZE);
    return CNT_W'(d);
  endfunction

  logic [PREG_IDX_WIDTH-1:0]           w_entry [FL_SIZE];
  logic [IDX_W:0]                      r_head;
  logic [IDX_W:0]                      r_tail;
  logic [IDX_W:0]                      r_rhead;
  logic                                r_freed_any;
  logic                                r_rst_seen;

  logic [SEL_W-1:0]                    w_nalloc;
  logic [SEL_W-1:0]                    w_nfree;
  logic [SCALAR-1:0][SEL_W-1:0]        w_alloc_pos;
  logic [SCALAR-1:0][SEL_W-1:0]        w_free_pos;
  logic [SCALAR-1:0][IDX_W-1:0]        w_wr_idx;
  logic [CNT_W-1:0]                    w_num_free;
  logic                                w_alloc_ok;
  logic                                w_alloc_fire;
  logic [IDX_W:0]                      w_rhead_next;

  freelist_slot_select #(.SCALAR(SCALAR)) u_alloc_sel (
    .valid (alloc_req),
    .count (w_nalloc),
    .pos   (w_alloc_pos)
  );

  freelist_slot_select #(.SCALAR(SCALAR)) u_free_sel (
    .valid (retire_en),
    .count (w_nfree),
    .pos   (w_free_pos)
  );

  // Per-slot compaction: the k-th requesting slot reads entry[head+k], the
  // k-th retiring slot writes entry[tail+k].
  for (genvar s = 0; s < SCALAR; s++) begin : g_slot
    logic [IDX_W-1:0] w_rd_idx;
    assign w_rd_idx      = idx_add(r_head[IDX_W-1:0], w_alloc_pos[s]);
    assign w_wr_idx[s]   = idx_add(r_tail[IDX_W-1:0], w_free_pos[s]);
    assign alloc_preg[s] = alloc_req[s] ? w_entry[w_rd_idx] : '0;
  end

  for (genvar e = 0; e < FL_SIZE; e++) begin : g_entry
    logic [PREG_IDX_WIDTH-1:0] r_val;
    always_ff @(posedge clock) begin
      if (reset) begin
        r_val <= PREG_IDX_WIDTH'(ARCH_NUM + e);
      end else begin
        for (int s = 0; s < SCALAR; s++) begin
          if (retire_en[s] && (w_wr_idx[s] == IDX_W'(e))) r_val <= retire_told[s];
        end
      end
    end
    assign w_entry[e] = r_val;
  end

  always_comb begin
    w_num_free   = ptr_dist(r_head, r_tail);
    w_alloc_ok   = (w_num_free >= CNT_W'(w_nalloc));
    w_alloc_fire = w_alloc_ok && !stall && !rollback && (w_nalloc != '0);
    w_rhead_next = ptr_add(r_rhead, w_nfree);
  end

  assign alloc_ok = w_alloc_ok;
  assign num_free = w_num_free;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_head      <= '0;
      r_rhead     <= '0;
      r_tail      <= {1'b1, {IDX_W{1'b0}}};
      r_freed_any <= 1'b0;
    end else begin
      r_tail  <= ptr_add(r_tail, w_nfree);
      r_rhead <= w_rhead_next;
      // Rollback wins over allocation and lands on the post-retire rhead.
      if (rollback) begin
        r_head <= w_rhead_next;
      end else if (w_alloc_fire) begin
        r_head <= ptr_add(r_head, w_nalloc);
      end
      if (|retire_en) r_freed_any <= 1'b1;
    end
  end

  // Structural invariants, active once a reset has been seen.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rst_seen <= 1'b1;
    end else if (r_rst_seen) begin
      // tail - rhead is always FL_SIZE, with head somewhere in between.
      assert (({1'b0, w_num_free} + {1'b0, ptr_dist(r_rhead, r_head)})
              == (CNT_W+1)'(FL_SIZE));
      // Frees can never push the list beyond capacity.
      assert (({1'b0, w_num_free} + (CNT_W+1)'(w_nfree)) <= (CNT_W+1)'(FL_SIZE));
      if (w_alloc_fire && !r_freed_any) begin
        for (int s = 0; s < SCALAR; s++) begin
          assert (!alloc_req[s] || (alloc_preg[s] >= PREG_IDX_WIDTH'(ARCH_NUM)));
        end
      end
    end
  end

endmodule : freelist
`default_nettype wire

// File: tb/tb_freelist.sv
`default_nettype none
// ============================================================================
// Module      : tb_freelist
// Description : Self-checking bench for freelist. A queue model holds the free
//               tags in allocation order plus the in-flight tags in program
//               order; directed scenarios pin known values, then randomized
//               alloc/retire/rollback traffic is compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_freelist;

  localparam int FL_SIZE  = 32;
  localparam int ARCH_NUM = 32;

  logic            clock = 1'b0;
  logic            reset;
  logic            stall;
  logic            rollback;
  logic [1:0]      alloc_req;
  logic            alloc_ok;
  logic [1:0][5:0] alloc_preg;
  logic [1:0]      retire_en;
  logic [1:0][5:0] retire_told;
  logic [5:0]      num_free;

  always #5 clock = ~clock;

  freelist dut (
    .clock       (clock),
    .reset       (reset),
    .stall       (stall),
    .rollback    (rollback),
    .alloc_req   (alloc_req),
    .alloc_ok    (alloc_ok),
    .alloc_preg  (alloc_preg),
    .retire_en   (retire_en),
    .retire_told (retire_told),
    .num_free    (num_free)
  );

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;
  bit rand_phase = 1'b0;

  // Model: free tags oldest-first, in-flight tags and their rd in program order.
  int free_q[$];
  int infl_q[$];
  int infl_rd[$];
  int rrat[32];
  int slot_rd[2];
  int rhead_lin;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic int pc2(input logic [1:0] v);
    return int'(v[0]) + int'(v[1]);
  endfunction

  function automatic int live_hits(input int tag);
    int n = 0;
    for (int r = 0; r < 32; r++) if (rrat[r] == tag) n++;
    foreach (infl_q[i]) if (infl_q[i] == tag) n++;
    return n;
  endfunction

  task automatic model_reset();
    free_q.delete();
    infl_q.delete();
    infl_rd.delete();
    for (int i = 0; i < FL_SIZE; i++) free_q.push_back(ARCH_NUM + i);
    for (int r = 0; r < 32; r++) rrat[r] = r;
    rhead_lin = 0;
  endtask

  // Applies what the coming clock edge does, given the inputs now driven.
  task automatic model_step();
    int  nreq;
    bit  ok;
    if (reset) begin
      model_reset();
      return;
    end
    nreq = pc2(alloc_req);
    ok   = (free_q.size() >= nreq);
    for (int s = 0; s < 2; s++) begin
      if (retire_en[s]) begin
        free_q.push_back(int'(retire_told[s]));
        rhead_lin++;
        if (infl_q.size() > 0) begin
          rrat[infl_rd[0]] = infl_q[0];
          void'(infl_q.pop_front());
          void'(infl_rd.pop_front());
        end
      end
    end
    if (rollback) begin
      free_q = {infl_q, free_q};
      infl_q.delete();
      infl_rd.delete();
    end else if (ok && !stall) begin
      for (int s = 0; s < 2; s++) begin
        if (alloc_req[s]) begin
          infl_q.push_back(free_q.pop_front());
          infl_rd.push_back(slot_rd[s]);
        end
      end
    end
  endtask

  int  cmp_nreq;
  int  cmp_k;
  bit  cmp_ok;

  always @(negedge clock) begin
    if (check_en && !reset) begin
      cmp_nreq = pc2(alloc_req);
      cmp_ok   = (free_q.size() >= cmp_nreq);
      chk("num_free", int'(num_free), free_q.size());
      chk("alloc_ok", int'(alloc_ok), int'(cmp_ok));
      cmp_k = 0;
      for (int s = 0; s < 2; s++) begin
        if (!alloc_req[s]) begin
          chk($sformatf("alloc_preg_idle[%0d]", s), int'(alloc_preg[s]), 0);
        end else begin
          if (cmp_ok) chk($sformatf("alloc_preg[%0d]", s), int'(alloc_preg[s]), free_q[cmp_k]);
          if (rand_phase && cmp_ok && !stall && !rollback)
            chk($sformatf("live_dup[%0d]", s), live_hits(int'(alloc_preg[s])), 0);
          cmp_k++;
        end
      end
    end
  end

  task automatic drive(input logic [1:0] req, input logic st, input logic rb,
                       input logic [1:0] ren, input logic [5:0] t1, input logic [5:0] t0);
    alloc_req      = req;
    stall          = st;
    rollback       = rb;
    retire_en      = ren;
    retire_told[1] = t1;
    retire_told[0] = t0;
  endtask

  task automatic tick();
    @(negedge clock);
    #1 model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(2'b00, 1'b0, 1'b0, 2'b00, 6'd0, 6'd0);
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    int         nret;
    int         k;
    int         rd;
    int         tmp[32];
    logic [1:0] req, ren;
    logic [5:0] told [2];

    slot_rd[0] = 1;
    slot_rd[1] = 2;
    reset = 1'b1;
    drive(2'b00, 1'b0, 1'b0, 2'b00, 6'd0, 6'd0);
    @(posedge clock);
    #1;
    check_en = 1'b1;

    // Reset layout and a two-wide grant.
    do_reset();
    drive(2'b11, 1'b0, 1'b0, 2'b00, 6'd0, 6'd0);
    #1;
    chk("rst_num_free", int'(num_free), 32);
    chk("rst_alloc_ok", int'(alloc_ok), 1);
    chk("rst_preg0", int'(alloc_preg[0]), 32);
    chk("rst_preg1", int'(alloc_preg[1]), 33);
    tick();
    chk("a2_num_free", int'(num_free), 30);
    chk("a2_preg0", int'(alloc_preg[0]), 34);
    chk("a2_preg1", int'(alloc_preg[1]), 35);

    // Single request on slot 1, then stall.
    do_reset();
    drive(2'b10, 1'b0, 1'b0, 2'b00, 6'd0, 6'd0);
    #1;
    chk("s1_preg1", int'(alloc_preg[1]), 32);
    chk("s1_preg0_idle", int'(alloc_preg[0]), 0);
    tick();
    chk("s1_num_free", int'(num_free), 31);
    drive(2'b11, 1'b1, 1'b0, 2'b00, 6'd0, 6'd0);
    tick();
    chk("stall_num_free", int'(num_free), 31);
    chk("stall_preg0", int'(alloc_preg[0]), 33);

    // Drain to one, then an over-request and the last grant.
    drive(2'b11, 1'b0, 1'b0, 2'b00, 6'd0, 6'd0);
    repeat (15) tick();
    chk("drain_num_free", int'(num_free), 1);
    chk("drain_alloc_ok", int'(alloc_ok), 0);
    tick();
    chk("nogrant_num_free", int'(num_free), 1);
    drive(2'b01, 1'b0, 1'b0, 2'b00, 6'd0, 6'd0);
    #1;
    chk("last_alloc_ok", int'(alloc_ok), 1);
    chk("last_preg0", int'(alloc_preg[0]), 63);
    tick();
    chk("empty_num_free", int'(num_free), 0);
    chk("empty_alloc_ok", int'(alloc_ok), 0);

    // Six allocated, two retired, rollback restores the squashed four.
    do_reset();
    drive(2'b11, 1'b0, 1'b0, 2'b00, 6'd0, 6'd0);
    repeat (3) tick();
    drive(2'b00, 1'b0, 1'b0, 2'b11, 6'd5, 6'd3);
    tick();
    chk("ret_num_free", int'(num_free), 28);
    drive(2'b00, 1'b0, 1'b1, 2'b00, 6'd0, 6'd0);
    tick();
    chk("rb_num_free", int'(num_free), 32);
    drive(2'b11, 1'b0, 1'b0, 2'b00, 6'd0, 6'd0);
    #1;
    chk("rb_preg0", int'(alloc_preg[0]), 34);
    chk("rb_preg1", int'(alloc_preg[1]), 35);
    tick();
    chk("rb2_preg0", int'(alloc_preg[0]), 36);
    chk("rb2_preg1", int'(alloc_preg[1]), 37);

    // Rollback together with a retire and an allocation request.
    do_reset();
    drive(2'b11, 1'b0, 1'b0, 2'b00, 6'd0, 6'd0);
    tick();
    drive(2'b01, 1'b0, 1'b0, 2'b00, 6'd0, 6'd0);
    tick();
    drive(2'b11, 1'b0, 1'b1, 2'b01, 6'd0, 6'd7);
    tick();
    chk("rbret_num_free", int'(num_free), 32);
    chk("rbret_preg0", int'(alloc_preg[0]), 33);
    chk("rbret_preg1", int'(alloc_preg[1]), 34);

    // Randomized traffic against the model.
    do_reset();
    rand_phase = 1'b1;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      req  = 2'($urandom_range(0, 3));
      nret = $urandom_range(0, (infl_q.size() < 2) ? infl_q.size() : 2);
      if (nret == 2)      ren = 2'b11;
      else if (nret == 1) ren = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      else                ren = 2'b00;
      tmp = rrat;
      k   = 0;
      for (int s = 0; s < 2; s++) begin
        slot_rd[s] = $urandom_range(1, 31);
        if (ren[s]) begin
          rd      = infl_rd[k];
          told[s] = 6'(tmp[rd]);
          tmp[rd] = infl_q[k];
          k++;
        end else begin
          told[s] = 6'($urandom_range(0, 63));
        end
      end
      drive(req, ($urandom_range(0, 9) == 0), ($urandom_range(0, 49) == 0),
            ren, told[1], told[0]);
      tick();
    end
    rand_phase = 1'b0;
    chk("wraps_over_20", int'((rhead_lin / FL_SIZE) > 20), 1);

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_freelist
`default_nettype wire
